wave_trace_reader: RTL and testbench

//  Display-side reader for the 2-bank x 200-sample waveform ping-pong RAM (8-bit AD samples).

---
 rtl/scope_pkg.sv | 18 +
 rtl/trace_seg_cmp.sv | 39 +++
 rtl/wave_trace_reader.sv | 203 ++++++++++++++++++++
 tb/tb_wave_trace_reader.sv | 249 ++++++++++++++++++++++++
 4 files changed

// File: rtl/scope_pkg.sv
// Shared scope constants and bank FSM encodings, also imported by the sampler writer.
package scope_pkg;

  localparam int unsigned DefX0     = 100;  // left edge of trace window
  localparam int unsigned DefY0     = 200;  // top edge of trace window
  localparam int unsigned DefNpts   = 200;  // samples per bank = window width
  localparam int unsigned DefHeight = 256;  // window height in rows
  localparam int unsigned DefDw     = 8;    // sample width
  localparam int unsigned DefAw     = 8;    // RAM address width
  localparam int unsigned CoordW    = 10;   // VGA coordinate width

  typedef enum logic [1:0] {
    StIdle = 2'd0,
    StShow = 2'd1,
    StPend = 2'd2
  } bank_state_e;

endpackage

// File: rtl/trace_seg_cmp.sv
// Registered test of whether row y lies on the vertical segment joining two sample rows.
module trace_seg_cmp
  import scope_pkg::*;
(
  input  logic              i_clk,
  input  logic              i_rst,
  input  logic              i_en,
  input  logic [CoordW-1:0] i_y,
  input  logic [CoordW-1:0] i_y_prev,
  input  logic [CoordW-1:0] i_y_cur,
  output logic              o_in_seg
);

  logic [CoordW-1:0] w_lo;
  logic [CoordW-1:0] w_hi;
  logic              r_in_seg;

  // Order the two segment endpoints.
  always_comb begin
    w_lo = i_y_cur;
    w_hi = i_y_prev;
    if (i_y_prev < i_y_cur) begin
      w_lo = i_y_prev;
      w_hi = i_y_cur;
    end
  end

  // Register the in-segment decision.
  always_ff @(posedge i_clk) begin
    if (i_rst) begin
      r_in_seg <= 1'b0;
    end else begin
      r_in_seg <= i_en && (i_y >= w_lo) && (i_y <= w_hi);
    end
  end

  assign o_in_seg = r_in_seg;

endmodule

// File: rtl/wave_trace_reader.sv
// Display-side reader for the ping-pong waveform RAM: bank hand-over at frame start and a
// fixed 3-clk read pipeline producing the trace pixel.
module wave_trace_reader
  import scope_pkg::*;
#(
  parameter int unsigned X0     = DefX0,
  parameter int unsigned Y0     = DefY0,
  parameter int unsigned NPTS   = DefNpts,
  parameter int unsigned HEIGHT = DefHeight,
  parameter int unsigned DW     = DefDw,
  parameter int unsigned AW     = DefAw
) (
  input  logic              i_clk,
  input  logic              i_rst,
  input  logic [CoordW-1:0] i_value_x,
  input  logic [CoordW-1:0] i_value_y,
  input  logic              i_frame_start,
  input  logic              i_buf_ready,
  input  logic              i_buf_id,
  input  logic              i_freeze,
  input  logic [DW-1:0]     i_rd_q,
  output logic [AW-1:0]     o_rd_addr,
  output logic              o_rd_sel,
  output logic              o_buf_free,
  output logic              o_free_id,
  output logic              o_pixel_on,
  output logic [7:0]        o_drop_cnt
);

  localparam logic [CoordW-1:0] LpXLo  = CoordW'(X0);
  localparam logic [CoordW-1:0] LpXHi  = CoordW'(X0 + NPTS);
  localparam logic [CoordW-1:0] LpYBot = CoordW'(Y0 + HEIGHT - 1);

  // Bank FSM state
  bank_state_e r_state, w_state_nxt;
  logic        r_pend_id, w_pend_id_nxt;
  logic        r_rd_sel, w_rd_sel_nxt;
  logic        r_shown, w_shown_nxt;  // a bank has been displayed since reset
  logic        r_buf_free, w_buf_free_nxt;
  logic        r_free_id, w_free_id_nxt;
  logic        w_drop_inc;
  logic [7:0]  r_drop_cnt;

  // Read pipeline state
  logic              w_inwin0;
  logic [AW-1:0]     r_rd_addr;
  logic              r_inwin1;
  logic [CoordW-1:0] r_y1;
  logic              r_inwin2;
  logic [CoordW-1:0] r_y2;
  logic [AW-1:0]     r_addr2;
  logic [AW-1:0]     r_last_addr;
  logic [CoordW-1:0] r_y_last;      // y of the most recent column seen
  logic [CoordW-1:0] r_y_prev_col;  // y of the column before the current one
  logic [CoordW-1:0] w_y_cur;
  logic [CoordW-1:0] w_y_prev;
  logic              w_col0;
  logic              w_new_col;
  logic              w_pix_en;

  // Bank hand-over decisions; swaps only happen on frame_start.
  always_comb begin
    w_state_nxt    = r_state;
    w_pend_id_nxt  = r_pend_id;
    w_rd_sel_nxt   = r_rd_sel;
    w_shown_nxt    = r_shown;
    w_buf_free_nxt = 1'b0;
    w_free_id_nxt  = r_free_id;
    w_drop_inc     = 1'b0;
    unique case (r_state)
      StIdle: begin
        if (i_buf_ready) begin
          w_state_nxt   = StPend;
          w_pend_id_nxt = i_buf_id;
        end
      end
      StShow: begin
        // frame_start alone does nothing here, so a coincident buf_ready waits a frame
        if (i_buf_ready) begin
          if (i_freeze) begin
            w_buf_free_nxt = 1'b1;
            w_free_id_nxt  = i_buf_id;
          end else begin
            w_state_nxt   = StPend;
            w_pend_id_nxt = i_buf_id;
          end
        end
      end
      StPend: begin
        if (i_buf_ready) begin
          // Newer bank supersedes the pending one; hand the old one back
          w_pend_id_nxt = i_buf_id;
          w_drop_inc    = 1'b1;
          if (i_buf_id != r_pend_id) begin
            w_buf_free_nxt = 1'b1;
            w_free_id_nxt  = r_pend_id;
          end
        end else if (i_frame_start && !i_freeze) begin
          w_state_nxt  = StShow;
          w_rd_sel_nxt = r_pend_id;
          w_shown_nxt  = 1'b1;
          if (r_shown && (r_rd_sel != r_pend_id)) begin
            w_buf_free_nxt = 1'b1;
            w_free_id_nxt  = r_rd_sel;
          end
        end
      end
      default: w_state_nxt = StIdle;
    endcase
  end

  // Bank FSM registers and saturating drop counter.
  always_ff @(posedge i_clk) begin
    if (i_rst) begin
      r_state    <= StIdle;
      r_pend_id  <= 1'b0;
      r_rd_sel   <= 1'b0;
      r_shown    <= 1'b0;
      r_buf_free <= 1'b0;
      r_free_id  <= 1'b0;
      r_drop_cnt <= 8'd0;
    end else begin
      r_state    <= w_state_nxt;
      r_pend_id  <= w_pend_id_nxt;
      r_rd_sel   <= w_rd_sel_nxt;
      r_shown    <= w_shown_nxt;
      r_buf_free <= w_buf_free_nxt;
      r_free_id  <= w_free_id_nxt;
      if (w_drop_inc && (r_drop_cnt != 8'hFF)) begin
        r_drop_cnt <= r_drop_cnt + 8'd1;
      end
    end
  end

  assign w_inwin0 = (i_value_x >= LpXLo) && (i_value_x < LpXHi);

  // S0: issue the RAM address for in-window columns; carry window flag and row along.
  always_ff @(posedge i_clk) begin
    if (i_rst) begin
      r_rd_addr <= '0;
      r_inwin1  <= 1'b0;
      r_y1      <= '0;
    end else begin
      if (w_inwin0) begin
        r_rd_addr <= AW'(i_value_x - LpXLo);
      end
      r_inwin1 <= w_inwin0;
      r_y1     <= i_value_y;
    end
  end

  // S1: align window flag, row and address with the registered RAM data.
  always_ff @(posedge i_clk) begin
    if (i_rst) begin
      r_inwin2 <= 1'b0;
      r_y2     <= '0;
      r_addr2  <= '0;
    end else begin
      r_inwin2 <= r_inwin1;
      r_y2     <= r_y1;
      r_addr2  <= r_rd_addr;
    end
  end

  // Sample 0 maps to the bottom row of the window.
  assign w_y_cur = LpYBot - CoordW'(i_rd_q);
  assign w_col0  = (r_addr2 == '0);
  // value_x may dwell on a column for several clocks; only a column change shifts history.
  assign w_new_col = r_inwin2 && ((r_addr2 != r_last_addr) || w_col0);
  assign w_y_prev  = w_col0    ? w_y_cur  :
                     w_new_col ? r_y_last : r_y_prev_col;
  assign w_pix_en  = r_inwin2 && r_shown;

  // S2: remember the sample row of the previous column.
  always_ff @(posedge i_clk) begin
    if (i_rst) begin
      r_last_addr  <= '0;
      r_y_last     <= '0;
      r_y_prev_col <= '0;
    end else if (w_new_col) begin
      r_last_addr  <= r_addr2;
      r_y_last     <= w_y_cur;
      r_y_prev_col <= r_y_last;
    end
  end

  trace_seg_cmp u_seg_cmp (
    .i_clk    (i_clk),
    .i_rst    (i_rst),
    .i_en     (w_pix_en),
    .i_y      (r_y2),
    .i_y_prev (w_y_prev),
    .i_y_cur  (w_y_cur),
    .o_in_seg (o_pixel_on)
  );

  assign o_rd_addr  = r_rd_addr;
  assign o_rd_sel   = r_rd_sel;
  assign o_buf_free = r_buf_free;
  assign o_free_id  = r_free_id;
  assign o_drop_cnt = r_drop_cnt;

endmodule

// File: tb/tb_wave_trace_reader.sv
// Self-checking bench for wave_trace_reader with a RAM model and a rule-level reference.
module tb_wave_trace_reader;

  logic       clk = 1'b0;
  logic       rst;
  logic [9:0] value_x, value_y;
  logic       frame_start, buf_ready, buf_id, freeze;
  logic [7:0] rd_q;
  logic [7:0] rd_addr;
  logic       rd_sel, buf_free, free_id, pixel_on;
  logic [7:0] drop_cnt;

  always #5 clk = ~clk;

  wave_trace_reader dut (
    .i_clk         (clk),
    .i_rst         (rst),
    .i_value_x     (value_x),
    .i_value_y     (value_y),
    .i_frame_start (frame_start),
    .i_buf_ready   (buf_ready),
    .i_buf_id      (buf_id),
    .i_freeze      (freeze),
    .i_rd_q        (rd_q),
    .o_rd_addr     (rd_addr),
    .o_rd_sel      (rd_sel),
    .o_buf_free    (buf_free),
    .o_free_id     (free_id),
    .o_pixel_on    (pixel_on),
    .o_drop_cnt    (drop_cnt)
  );

  // Ping-pong RAM with registered read
  logic [7:0] mem [2][200];
  always @(posedge clk) begin
    if (rd_addr < 8'd200) rd_q <= mem[rd_sel][rd_addr];
  end

  // Reference model
  bit m_shown, m_has_pend, m_bank, m_pend, m_fid;
  int m_drops;
  int n_checks, n_fail;

  typedef struct {int x; int y; bit e;} px_t;
  px_t exp_q[$];

  // Trace pixel from the display rules: segment between this column's and previous column's row.
  function automatic bit exp_pix(int x, int y);
    int c, yc, yp, lo, hi;
    if (!m_shown || x < 100 || x >= 300) return 1'b0;
    c  = x - 100;
    yc = 455 - int'(mem[m_bank][c]);
    yp = (c == 0) ? yc : 455 - int'(mem[m_bank][c-1]);
    lo = (yp < yc) ? yp : yc;
    hi = (yp < yc) ? yc : yp;
    return (y >= lo) && (y <= hi);
  endfunction

  task automatic drive_px(int x, int y);
    px_t p;
    @(negedge clk);
    if (exp_q.size() == 3) begin
      p = exp_q.pop_front();
      n_checks++;
      if (pixel_on !== p.e) begin
        n_fail++;
        $display("FAIL pixel x=%0d y=%0d got %b want %b", p.x, p.y, pixel_on, p.e);
      end
    end
    value_x = 10'(x);
    value_y = 10'(y);
    p.x = x; p.y = y; p.e = exp_pix(x, y);
    exp_q.push_back(p);
  endtask

  task automatic flush_px();
    repeat (3) drive_px(0, 0);
    exp_q.delete();
  endtask

  task automatic scan_row(int y, int xs, int xe, int rep);
    for (int x = xs; x <= xe; x++) begin
      repeat (rep) drive_px(x, y);
    end
  endtask

  task automatic fill_bank(int b, int mode);
    for (int i = 0; i < 200; i++) mem[b][i] = (mode < 0) ? 8'($urandom) : 8'(mode);
  endtask

  task automatic ctrl(bit br, bit id, bit fs, bit frz);
    bit exp_free;
    @(negedge clk);
    value_x = 10'd0;
    buf_ready = br; buf_id = id; frame_start = fs; freeze = frz;
    exp_free = 1'b0;
    if (!m_shown && !m_has_pend) begin
      if (br) begin m_has_pend = 1'b1; m_pend = id; end
    end else if (!m_has_pend) begin
      if (br) begin
        if (frz) begin exp_free = 1'b1; m_fid = id; end
        else begin m_has_pend = 1'b1; m_pend = id; end
      end
    end else begin
      if (br) begin
        if (m_drops < 255) m_drops++;
        if (id != m_pend) begin exp_free = 1'b1; m_fid = m_pend; end
        m_pend = id;
      end else if (fs && !frz) begin
        if (m_shown && m_bank != m_pend) begin exp_free = 1'b1; m_fid = m_bank; end
        m_bank = m_pend; m_shown = 1'b1; m_has_pend = 1'b0;
      end
    end
    @(negedge clk);
    buf_ready = 1'b0; frame_start = 1'b0; freeze = 1'b0;
    n_checks += 3;
    if (rd_sel !== m_bank) begin
      n_fail++; $display("FAIL rd_sel got %b want %b", rd_sel, m_bank);
    end
    if (buf_free !== exp_free) begin
      n_fail++; $display("FAIL buf_free got %b want %b", buf_free, exp_free);
    end
    if (drop_cnt !== 8'(m_drops)) begin
      n_fail++; $display("FAIL drop_cnt got %0d want %0d", drop_cnt, m_drops);
    end
    if (exp_free) begin
      n_checks++;
      if (free_id !== m_fid) begin
        n_fail++; $display("FAIL free_id got %b want %b", free_id, m_fid);
      end
    end
  endtask

  task automatic do_reset();
    @(negedge clk);
    rst = 1'b1; buf_ready = 1'b0; frame_start = 1'b0; freeze = 1'b0;
    @(negedge clk);
    rst = 1'b0;
    m_shown = 0; m_has_pend = 0; m_bank = 0; m_pend = 0; m_fid = 0; m_drops = 0;
    exp_q.delete();
    n_checks++;
    if ({rd_addr, rd_sel, buf_free, free_id, pixel_on, drop_cnt} !== 20'd0) begin
      n_fail++;
      $display("FAIL reset_state got addr=%0d sel=%b free=%b fid=%b pix=%b drop=%0d want all 0",
               rd_addr, rd_sel, buf_free, free_id, pixel_on, drop_cnt);
    end
  endtask

  task automatic show_bank(bit b);
    ctrl(1'b1, b, 1'b0, 1'b0);
    ctrl(1'b0, 1'b0, 1'b1, 1'b0);
  endtask

  task automatic test_reset();
    do_reset();
  endtask

  task automatic test_first_show();
    do_reset();
    fill_bank(1, 128);
    ctrl(1'b1, 1'b1, 1'b0, 1'b0);
    scan_row(327, 95, 305, 1);  // nothing displayed yet
    flush_px();
    ctrl(1'b0, 1'b0, 1'b1, 1'b0);
  endtask

  task automatic test_flat();
    scan_row(327, 95, 305, 1);
    scan_row(326, 95, 305, 1);
    scan_row(328, 95, 305, 1);
    scan_row(199, 95, 305, 1);
    scan_row(456, 95, 305, 1);
    flush_px();
  endtask

  task automatic test_vertical();
    mem[1][9]  = 8'd0;
    mem[1][10] = 8'd255;
    for (int y = 195; y <= 460; y++) scan_row(y, 98, 112, 1);
    flush_px();
  endtask

  task automatic test_swap();
    do_reset();
    show_bank(1'b0);
    show_bank(1'b1);                  // release of bank 0 with the swap
    ctrl(1'b1, 1'b0, 1'b1, 1'b0);     // coincident: no swap this frame
    ctrl(1'b0, 1'b0, 1'b1, 1'b0);
  endtask

  task automatic test_freeze();
    do_reset();
    show_bank(1'b0);
    ctrl(1'b1, 1'b1, 1'b0, 1'b1);     // refused, released straight back
    ctrl(1'b1, 1'b1, 1'b0, 1'b0);
    ctrl(1'b0, 1'b0, 1'b1, 1'b1);     // deferred
    ctrl(1'b1, 1'b0, 1'b0, 1'b0);     // supersede: drop 1
    ctrl(1'b0, 1'b0, 1'b1, 1'b0);     // same bank as shown: no release
  endtask

  task automatic test_random();
    for (int r = 0; r < 6; r++) begin
      for (int k = 0; k < 30; k++) begin
        ctrl(($urandom % 3) == 0, 1'($urandom), ($urandom % 4) == 0, ($urandom % 4) == 0);
      end
      fill_bank(0, -1);
      fill_bank(1, -1);
      for (int k = 0; k < 3; k++) begin
        int y;
        if ($urandom % 2 == 0) y = 455 - int'(mem[m_bank][$urandom_range(0, 199)]);
        else y = int'($urandom_range(0, 600));
        scan_row(y, 96, 303, int'($urandom_range(1, 2)));
      end
      flush_px();
    end
  endtask

  task automatic test_reset_midline();
    do_reset();
    show_bank(1'b0);
    ctrl(1'b1, 1'b1, 1'b0, 1'b0);
    for (int i = 0; i < 300; i++) ctrl(1'b1, 1'(i % 2), 1'b0, 1'b0);
    ctrl(1'b0, 1'b0, 1'b1, 1'b0);
    fill_bank(1, 128);
    scan_row(327, 95, 150, 1);        // pipeline now full of lit pixels
    do_reset();
    scan_row(327, 98, 110, 1);
    flush_px();
  endtask

  initial begin
    n_checks = 0; n_fail = 0;
    rst = 1'b1; value_x = '0; value_y = '0;
    frame_start = 1'b0; buf_ready = 1'b0; buf_id = 1'b0; freeze = 1'b0;
    fill_bank(0, 0);
    fill_bank(1, 0);
    test_reset();
    test_first_show();
    test_flat();
    test_vertical();
    test_swap();
    test_freeze();
    test_random();
    test_reset_midline();
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
